comp_result_tracker: RTL and testbench

//  Sequential stage directly downstream of the 2-bit magnitude comparator (comp).

---
 rtl/comp_result_tracker_if.sv | 27 ++
 rtl/comp_result_tracker.sv | 139 +++++++++++++
 tb/tb_comp_result_tracker.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/comp_result_tracker_if.sv
// comp_result_tracker_if: sample/clear inputs and tracker outputs for the
// comparator result tracker. The master drives samples, the slave is the tracker.
interface comp_result_tracker_if #(
   parameter int CW = 8
);
   logic          in_valid;
   logic          greater;
   logic          equal;
   logic          less;
   logic          clr;
   logic          stable_valid;
   logic [1:0]    stable_code;
   logic [CW-1:0] cnt_gt;
   logic [CW-1:0] cnt_eq;
   logic [CW-1:0] cnt_lt;
   logic          err;

   modport master (
      output in_valid, greater, equal, less, clr,
      input  stable_valid, stable_code, cnt_gt, cnt_eq, cnt_lt, err
   );

   modport slave (
      input  in_valid, greater, equal, less, clr,
      output stable_valid, stable_code, cnt_gt, cnt_eq, cnt_lt, err
   );
endinterface

// File: rtl/comp_result_tracker.sv
// comp_result_tracker: counts greater/equal/less outcomes of the upstream
// magnitude comparator, reports an outcome as stable after STABLE_N identical
// valid samples in a row, and latches a sticky error on non-one-hot flags.
// Optional build macro COMP_TRK_SAT_EN: outcome counters saturate at all-ones
// instead of wrapping to zero.
module comp_result_tracker #(
   parameter int CW       = 8,
   parameter int STABLE_N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   comp_result_tracker_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TRACK  = 2'd1,
      STABLE = 2'd2,
      ERROR  = 2'd3
   } state_t;

   localparam logic [1:0] CODE_NONE = 2'b00;
   localparam logic [1:0] CODE_GT   = 2'b01;
   localparam logic [1:0] CODE_EQ   = 2'b10;
   localparam logic [1:0] CODE_LT   = 2'b11;
   localparam logic [7:0] RUN_MAX   = 8'(STABLE_N);

   state_t        state_q, state_d;
   logic [7:0]    run_q, run_d;
   logic [1:0]    last_q, last_d;
   logic [CW-1:0] cnt_gt_q, cnt_gt_d;
   logic [CW-1:0] cnt_eq_q, cnt_eq_d;
   logic [CW-1:0] cnt_lt_q, cnt_lt_d;
   logic          err_q, err_d;
   logic          sv_q, sv_d;
   logic [1:0]    sc_q, sc_d;

   logic          legal;
   logic [1:0]    code;

   // Counter advance: wraps by default, holds at all-ones when saturation is built in.
   function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
`ifdef COMP_TRK_SAT_EN
      cnt_inc = (&c) ? c : c + 1'b1;
`else
      cnt_inc = c + 1'b1;
`endif
   endfunction

   assign legal = ({bus.greater, bus.equal, bus.less} == 3'b100) ||
                  ({bus.greater, bus.equal, bus.less} == 3'b010) ||
                  ({bus.greater, bus.equal, bus.less} == 3'b001);
   assign code  = bus.greater ? CODE_GT : (bus.equal ? CODE_EQ : CODE_LT);

   // Next-state, run tracking, counters and registered output values.
   always_comb begin
      state_d  = state_q;
      run_d    = run_q;
      last_d   = last_q;
      cnt_gt_d = cnt_gt_q;
      cnt_eq_d = cnt_eq_q;
      cnt_lt_d = cnt_lt_q;
      err_d    = err_q;

      if (bus.clr) begin
         // clear wins over any sample presented in the same cycle
         state_d  = IDLE;
         run_d    = '0;
         last_d   = CODE_NONE;
         cnt_gt_d = '0;
         cnt_eq_d = '0;
         cnt_lt_d = '0;
         err_d    = 1'b0;
      end else if (bus.in_valid && (state_q != ERROR)) begin
         if (!legal) begin
            state_d = ERROR;
            run_d   = '0;
            last_d  = CODE_NONE;
            err_d   = 1'b1;
         end else begin
            case (code)
               CODE_GT: cnt_gt_d = cnt_inc(cnt_gt_q);
               CODE_EQ: cnt_eq_d = cnt_inc(cnt_eq_q);
               default: cnt_lt_d = cnt_inc(cnt_lt_q);
            endcase

            if (code == last_q) begin
               run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + 8'd1;
            end else begin
               run_d = 8'd1;
            end
            last_d = code;

            case (state_q)
               IDLE:    state_d = TRACK;
               TRACK:   state_d = (run_d == RUN_MAX) ? STABLE : TRACK;
               STABLE:  state_d = (code == last_q) ? STABLE : TRACK;
               default: state_d = state_q;
            endcase
         end
      end

      sv_d = (state_d == STABLE);
      sc_d = sv_d ? last_d : CODE_NONE;
   end

   // State and output registers, cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         run_q    <= '0;
         last_q   <= CODE_NONE;
         cnt_gt_q <= '0;
         cnt_eq_q <= '0;
         cnt_lt_q <= '0;
         err_q    <= 1'b0;
         sv_q     <= 1'b0;
         sc_q     <= CODE_NONE;
      end else begin
         state_q  <= state_d;
         run_q    <= run_d;
         last_q   <= last_d;
         cnt_gt_q <= cnt_gt_d;
         cnt_eq_q <= cnt_eq_d;
         cnt_lt_q <= cnt_lt_d;
         err_q    <= err_d;
         sv_q     <= sv_d;
         sc_q     <= sc_d;
      end
   end

   assign bus.stable_valid = sv_q;
   assign bus.stable_code  = sc_q;
   assign bus.cnt_gt       = cnt_gt_q;
   assign bus.cnt_eq       = cnt_eq_q;
   assign bus.cnt_lt       = cnt_lt_q;
   assign bus.err          = err_q;

endmodule

// File: tb/tb_comp_result_tracker.sv
// tb_comp_result_tracker: scoreboard bench for comp_result_tracker.
// Main instance CW=8/STABLE_N=4 is checked cycle by cycle against a behavioural
// model; a second CW=2 instance exercises counter overflow.
module tb_comp_result_tracker;

   localparam int STB = 4;

   typedef struct packed {
      logic       sv;
      logic [1:0] sc;
      logic [7:0] gt;
      logic [7:0] eq;
      logic [7:0] lt;
      logic       err;
   } snap_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   comp_result_tracker_if #(.CW(8)) bus ();
   comp_result_tracker_if #(.CW(2)) bus2 ();

   comp_result_tracker #(.CW(8), .STABLE_N(STB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   comp_result_tracker #(.CW(2), .STABLE_N(STB)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   always #5 clk = ~clk;

   int    n_cmp = 0;
   int    n_bad = 0;
   snap_t exp_q[$];
   snap_t obs_q[$];

   // behavioural model state
   int         m_cnt [4];
   int         m_run;
   logic [1:0] m_last;
   logic       m_err;

   function automatic snap_t dut_snap();
      snap_t s;
      s.sv  = bus.stable_valid;
      s.sc  = bus.stable_code;
      s.gt  = bus.cnt_gt;
      s.eq  = bus.cnt_eq;
      s.lt  = bus.cnt_lt;
      s.err = bus.err;
      return s;
   endfunction

   function automatic snap_t model_snap();
      snap_t s;
      s.sv  = !m_err && (m_run == STB);
      s.sc  = s.sv ? m_last : 2'b00;
      s.gt  = 8'(m_cnt[1]);
      s.eq  = 8'(m_cnt[2]);
      s.lt  = 8'(m_cnt[3]);
      s.err = m_err;
      return s;
   endfunction

   function automatic int bump(input int x);
`ifdef COMP_TRK_SAT_EN
      return (x == 255) ? x : x + 1;
`else
      return (x + 1) % 256;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_run  = 0;
      m_last = 2'b00;
      m_err  = 1'b0;
   endtask

   task automatic model_step(input logic v, input logic g, input logic e,
                             input logic l, input logic c);
      int         n;
      logic [1:0] cd;
      if (c) begin
         model_reset();
      end else if (v && !m_err) begin
         n = int'(g) + int'(e) + int'(l);
         if (n != 1) begin
            m_run  = 0;
            m_last = 2'b00;
            m_err  = 1'b1;
         end else begin
            cd = g ? 2'd1 : (e ? 2'd2 : 2'd3);
            m_cnt[cd] = bump(m_cnt[cd]);
            if (cd == m_last) m_run = (m_run < STB) ? m_run + 1 : STB;
            else              m_run = 1;
            m_last = cd;
         end
      end
   endtask

   // Drive one cycle on the main instance; expected result queued at drive time,
   // observed result captured one edge later.
   task automatic step(input logic v, input logic g, input logic e,
                       input logic l, input logic c);
      bus.in_valid = v;
      bus.greater  = g;
      bus.equal    = e;
      bus.less     = l;
      bus.clr      = c;
      model_step(v, g, e, l, c);
      exp_q.push_back(model_snap());
      @(posedge clk);
      #1;
      obs_q.push_back(dut_snap());
      bus.in_valid = 1'b0;
      bus.clr      = 1'b0;
   endtask

   task automatic test_reset();
      snap_t o, e;
      o = dut_snap();
      n_cmp++;
      if (o !== '0) begin
         n_bad++;
         $display("FAIL reset_init: got %h required 0", o);
      end
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL reset_run: got %h required %h", o, e);
         end
      end
      n_cmp++;
      if (bus.cnt_gt !== 8'd3) begin
         n_bad++;
         $display("FAIL reset_pre_cnt: cnt_gt=%0d required 3", bus.cnt_gt);
      end
      // async assertion well away from any clock edge
      #2;
      rst = 1'b1;
      #1;
      o = dut_snap();
      n_cmp++;
      if (o !== '0) begin
         n_bad++;
         $display("FAIL reset_async: got %h required 0", o);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_stable();
      snap_t o, e;
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL stable_seq: got %h required %h", o, e);
         end
      end
      n_cmp++;
      if ({bus.stable_valid, bus.stable_code, bus.cnt_gt} !== {1'b1, 2'b01, 8'd4}) begin
         n_bad++;
         $display("FAIL stable_gt: sv=%0d code=%0d cnt_gt=%0d required 1/1/4",
                  bus.stable_valid, bus.stable_code, bus.cnt_gt);
      end
   endtask

   task automatic test_gap();
      snap_t o, e;
      step(0, 0, 0, 0, 1);
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      n_cmp++;
      if (bus.stable_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL gap_early: sv=%0d required 0", bus.stable_valid);
      end
      step(1, 1, 0, 0, 0);
      n_cmp++;
      if ({bus.stable_valid, bus.stable_code} !== 3'b101) begin
         n_bad++;
         $display("FAIL gap_stable: sv=%0d code=%0d required 1/1", bus.stable_valid, bus.stable_code);
      end
      step(1, 0, 1, 0, 0);
      n_cmp++;
      if ({bus.stable_valid, bus.cnt_eq, bus.cnt_gt} !== {1'b0, 8'd1, 8'd4}) begin
         n_bad++;
         $display("FAIL gap_break: sv=%0d cnt_eq=%0d cnt_gt=%0d required 0/1/4",
                  bus.stable_valid, bus.cnt_eq, bus.cnt_gt);
      end
      // back-to-back: eq run becomes stable after three more eq samples
      for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
      n_cmp++;
      if ({bus.stable_valid, bus.stable_code} !== 3'b110) begin
         n_bad++;
         $display("FAIL gap_eq_stable: sv=%0d code=%0d required 1/2", bus.stable_valid, bus.stable_code);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL gap_seq: got %h required %h", o, e);
         end
      end
   endtask

   task automatic test_illegal();
      snap_t o, e;
      step(0, 0, 0, 0, 1);
      step(1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0);
      n_cmp++;
      if ({bus.err, bus.cnt_gt, bus.cnt_eq, bus.stable_valid} !== {1'b1, 8'd1, 8'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL illegal_flag: err=%0d cnt_gt=%0d cnt_eq=%0d sv=%0d required 1/1/0/0",
                  bus.err, bus.cnt_gt, bus.cnt_eq, bus.stable_valid);
      end
      for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
      step(1, 0, 1, 0, 0);
      n_cmp++;
      if ({bus.err, bus.cnt_gt, bus.cnt_eq, bus.stable_valid} !== {1'b1, 8'd1, 8'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL illegal_ignore: err=%0d cnt_gt=%0d cnt_eq=%0d sv=%0d required 1/1/0/0",
                  bus.err, bus.cnt_gt, bus.cnt_eq, bus.stable_valid);
      end
      step(0, 0, 0, 0, 1);
      n_cmp++;
      if ({bus.err, bus.cnt_gt, bus.cnt_eq, bus.cnt_lt} !== 25'd0) begin
         n_bad++;
         $display("FAIL illegal_clr: err=%0d cnt_gt=%0d required 0/0", bus.err, bus.cnt_gt);
      end
      step(1, 0, 0, 0, 0);
      step(1, 1, 1, 1, 0);
      step(0, 0, 0, 0, 1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL illegal_seq: got %h required %h", o, e);
         end
      end
   endtask

   task automatic test_clr_priority();
      snap_t o, e;
      step(1, 0, 0, 1, 0);
      step(1, 0, 0, 1, 0);
      step(1, 0, 0, 1, 1);
      n_cmp++;
      if ({bus.cnt_lt, bus.cnt_gt, bus.cnt_eq} !== 24'd0) begin
         n_bad++;
         $display("FAIL clr_prio: cnt_lt=%0d required 0", bus.cnt_lt);
      end
      for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL clr_seq: got %h required %h", o, e);
         end
      end
   endtask

   task automatic test_random();
      snap_t       o, e;
      logic [2:0]  f;
      logic        v, c;
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 300; i++) begin
         v = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 19) == 0) f = 3'($urandom_range(0, 7));
         else if ($urandom_range(0, 2) == 0) f = 3'b001 << $urandom_range(0, 2);
         else f = (i % 9 < 5) ? 3'b100 : 3'b010;
         step(v, f[2], f[1], f[0], c);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL random_seq: got %h required %h", o, e);
         end
      end
   endtask

   task automatic test_wrap();
      int exp_cnt;
      bus2.clr = 1'b1;
      @(posedge clk);
      #1;
      bus2.clr = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         bus2.in_valid = 1'b1;
         bus2.less     = 1'b1;
         @(posedge clk);
         #1;
         bus2.in_valid = 1'b0;
`ifdef COMP_TRK_SAT_EN
         exp_cnt = (i < 3) ? i : 3;
`else
         exp_cnt = i % 4;
`endif
         n_cmp++;
         if ({bus2.cnt_lt, bus2.stable_valid} !== {2'(exp_cnt), (i >= STB)}) begin
            n_bad++;
            $display("FAIL wrap_cnt_lt: sample %0d cnt_lt=%0d sv=%0d required %0d/%0d",
                     i, bus2.cnt_lt, bus2.stable_valid, exp_cnt, (i >= STB));
         end
      end
      n_cmp++;
      if ({bus2.stable_code, bus2.cnt_gt, bus2.err} !== {2'b11, 2'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL wrap_code: code=%0d cnt_gt=%0d err=%0d required 3/0/0",
                  bus2.stable_code, bus2.cnt_gt, bus2.err);
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.greater   = 1'b0;
      bus.equal     = 1'b0;
      bus.less      = 1'b0;
      bus.clr       = 1'b0;
      bus2.in_valid = 1'b0;
      bus2.greater  = 1'b0;
      bus2.equal    = 1'b0;
      bus2.less     = 1'b0;
      bus2.clr      = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      test_reset();
      test_stable();
      test_gap();
      test_illegal();
      test_clr_priority();
      test_random();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
